// File: rtl/dist_sequencer_if.sv
// Handshake bundle between the distance sequencer and its host, pipes, accumulator, sqrt and BRAM.
// The master modport is the sequencer's view; the slave modport is the surrounding system's view.
interface dist_sequencer_if #(
    parameter int CW = 8,
    parameter int AW = 12
);
    logic          STARTCALC;
    logic [CW-1:0] NUM_OF_VECTORS;
    logic [CW-1:0] VECTOR_WIDTH;
    logic          MODE;
    logic          RDY_Acc;
    logic          RDY_Sqrt;
    logic          EN_Pipe;
    logic          EN_Acc;
    logic          RST_Acc;
    logic          PRE_Acc;
    logic          EN_Sqrt;
    logic          RES_SEL;
    logic [AW-1:0] ADDR_Bram;
    logic [2:0]    FLAG_Bram;
    logic [CW-1:0] VEC_IDX;
    logic          BUSY;
    logic          DONE;

    modport master (
        input  STARTCALC, NUM_OF_VECTORS, VECTOR_WIDTH, MODE, RDY_Acc, RDY_Sqrt,
        output EN_Pipe, EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, RES_SEL,
        output ADDR_Bram, FLAG_Bram, VEC_IDX, BUSY, DONE
    );

    modport slave (
        output STARTCALC, NUM_OF_VECTORS, VECTOR_WIDTH, MODE, RDY_Acc, RDY_Sqrt,
        input  EN_Pipe, EN_Acc, RST_Acc, PRE_Acc, EN_Sqrt, RES_SEL,
        input  ADDR_Bram, FLAG_Bram, VEC_IDX, BUSY, DONE
    );
endinterface

// File: rtl/dist_sequencer.sv
// Control sequencer for the distance datapath: per vector it streams LANES-wide chunks from BRAM
// through the pipes into the accumulator, optionally runs sqrt, and writes the result back.
module dist_sequencer #(
    parameter int CW          = 8,
    parameter int AW          = 12,
    parameter int LANES       = 4,
    parameter int DATA_BASE   = 0,
    parameter int RESULT_BASE = 2048
) (
    input  logic            clk,
    input  logic            RST,
    dist_sequencer_if.master bus
);
    localparam int            LANES_LG     = $clog2(LANES);
    localparam logic [AW-1:0] DATA_BASE_A  = AW'(DATA_BASE);
    localparam logic [AW-1:0] RESULT_BASE_A = AW'(RESULT_BASE);
    localparam logic [AW-1:0] LANES_A      = AW'(LANES);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HARD_RST  = 4'd1,
        S_READ      = 4'd2,
        S_FEED      = 4'd3,
        S_WAIT_ACC  = 4'd4,
        S_SOFT_RST  = 4'd5,
        S_WAIT_SQRT = 4'd6,
        S_WRITE     = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    state_t        state_r;
    logic [CW-1:0] nvec_r;
    logic          mode_r;
    logic [CW:0]   nch_r;
    logic [CW:0]   chunk_r;
    logic [AW-1:0] dptr_r;
    logic [CW-1:0] vec_idx_r;

    logic          en_pipe_r;
    logic          en_acc_r;
    logic          rst_acc_r;
    logic          pre_acc_r;
    logic          en_sqrt_r;
    logic          res_sel_r;
    logic [AW-1:0] addr_r;
    logic [2:0]    flag_r;
    logic          busy_r;
    logic          done_r;

    // Sequencer FSM; every output is registered from the state being processed on this edge.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r   <= S_IDLE;
            nvec_r    <= '0;
            mode_r    <= 1'b0;
            nch_r     <= '0;
            chunk_r   <= '0;
            dptr_r    <= '0;
            vec_idx_r <= '0;
            en_pipe_r <= 1'b0;
            en_acc_r  <= 1'b0;
            rst_acc_r <= 1'b0;
            pre_acc_r <= 1'b0;
            en_sqrt_r <= 1'b0;
            res_sel_r <= 1'b0;
            addr_r    <= '0;
            flag_r    <= 3'b000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // Strobes and BRAM flags fall back to idle unless the current state drives them.
            en_pipe_r <= 1'b0;
            en_acc_r  <= 1'b0;
            rst_acc_r <= 1'b0;
            pre_acc_r <= 1'b0;
            en_sqrt_r <= 1'b0;
            res_sel_r <= 1'b0;
            flag_r    <= 3'b000;
            done_r    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.STARTCALC) begin
                        nvec_r    <= bus.NUM_OF_VECTORS;
                        mode_r    <= bus.MODE;
                        nch_r     <= ({1'b0, bus.VECTOR_WIDTH} + (CW+1)'(LANES - 1)) >> LANES_LG;
                        dptr_r    <= DATA_BASE_A;
                        vec_idx_r <= '0;
                        chunk_r   <= '0;
                        busy_r    <= 1'b1;
                        if ((bus.NUM_OF_VECTORS == '0) || (bus.VECTOR_WIDTH == '0)) begin
                            state_r <= S_FINISH;
                        end else begin
                            state_r <= S_HARD_RST;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_HARD_RST: begin
                    rst_acc_r <= 1'b1;
                    en_acc_r  <= 1'b1;
                    chunk_r   <= '0;
                    state_r   <= S_READ;
                end
                S_READ: begin
                    en_acc_r <= 1'b1;
                    flag_r   <= 3'b101;
                    addr_r   <= dptr_r;
                    state_r  <= S_FEED;
                end
                S_FEED: begin
                    en_acc_r  <= 1'b1;
                    en_pipe_r <= 1'b1;
                    flag_r    <= 3'b101;
                    dptr_r    <= dptr_r + LANES_A;
                    chunk_r   <= chunk_r + (CW+1)'(1);
                    state_r   <= S_WAIT_ACC;
                end
                S_WAIT_ACC: begin
                    en_acc_r <= 1'b1;
                    if (bus.RDY_Acc) begin
                        if (chunk_r < nch_r) begin
                            state_r <= S_SOFT_RST;
                        end else if (mode_r) begin
                            state_r <= S_WRITE;
                        end else begin
                            state_r <= S_WAIT_SQRT;
                        end
                    end else begin
                        state_r <= S_WAIT_ACC;
                    end
                end
                S_SOFT_RST: begin
                    rst_acc_r <= 1'b1;
                    pre_acc_r <= 1'b1;
                    en_acc_r  <= 1'b1;
                    state_r   <= S_READ;
                end
                S_WAIT_SQRT: begin
                    en_acc_r  <= 1'b1;
                    en_sqrt_r <= 1'b1;
                    if (bus.RDY_Sqrt) begin
                        state_r <= S_WRITE;
                    end else begin
                        state_r <= S_WAIT_SQRT;
                    end
                end
                S_WRITE: begin
                    flag_r    <= 3'b110;
                    addr_r    <= RESULT_BASE_A + AW'(vec_idx_r);
                    res_sel_r <= ~mode_r;
                    // Compare before incrementing so nvec = 2^CW-1 never wraps VEC_IDX.
                    if (vec_idx_r == (nvec_r - CW'(1))) begin
                        state_r <= S_FINISH;
                    end else begin
                        vec_idx_r <= vec_idx_r + CW'(1);
                        state_r   <= S_HARD_RST;
                    end
                end
                S_FINISH: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.EN_Pipe   = en_pipe_r;
    assign bus.EN_Acc    = en_acc_r;
    assign bus.RST_Acc   = rst_acc_r;
    assign bus.PRE_Acc   = pre_acc_r;
    assign bus.EN_Sqrt   = en_sqrt_r;
    assign bus.RES_SEL   = res_sel_r;
    assign bus.ADDR_Bram = addr_r;
    assign bus.FLAG_Bram = flag_r;
    assign bus.VEC_IDX   = vec_idx_r;
    assign bus.BUSY      = busy_r;
    assign bus.DONE      = done_r;
endmodule

// File: tb/tb_dist_sequencer.sv
// Self-checking bench for dist_sequencer: directed and random jobs compared against a
// transaction-level expectation (read/write address lists, strobe patterns, job latency).
module tb_dist_sequencer;
    localparam int LANES = 4;
    localparam int DBASE = 0;
    localparam int RBASE = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Responder configuration, set by the stimulus before each job.
    bit   acc_hold = 1'b1;
    bit   sqrt_hold = 1'b1;
    bit   spurious = 1'b0;
    int   acc_delay = 0;
    int   sqrt_delay = 1;
    bit   acc_armed = 1'b0;
    bit   sqrt_armed = 1'b0;
    int   acc_cnt = 0;
    int   sqrt_cnt = 0;
    logic sq_prev = 1'b0;

    dist_sequencer_if #(.CW(8), .AW(12)) bus ();

    dist_sequencer #(
        .CW(8), .AW(12), .LANES(LANES), .DATA_BASE(DBASE), .RESULT_BASE(RBASE)
    ) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Accumulator / sqrt models: answer after a programmable delay, optionally with stray pulses.
    always @(negedge clk) begin
        if (rst) begin
            acc_armed = 1'b0;
            sqrt_armed = 1'b0;
            bus.RDY_Acc = 1'b0;
            bus.RDY_Sqrt = 1'b0;
            sq_prev = 1'b0;
        end else begin
            if (acc_hold) begin
                bus.RDY_Acc = 1'b1;
            end else begin
                bus.RDY_Acc = 1'b0;
                if (bus.EN_Pipe) begin
                    acc_armed = 1'b1;
                    acc_cnt = acc_delay;
                end
                if (acc_armed) begin
                    if (acc_cnt == 0) begin
                        bus.RDY_Acc = 1'b1;
                        acc_armed = 1'b0;
                    end else begin
                        acc_cnt--;
                    end
                end else if (spurious && (bus.RST_Acc || (bus.FLAG_Bram == 3'b101 && !bus.EN_Pipe))) begin
                    bus.RDY_Acc = 1'b1;
                end
            end
            if (sqrt_hold) begin
                bus.RDY_Sqrt = 1'b1;
            end else begin
                bus.RDY_Sqrt = 1'b0;
                if (bus.EN_Sqrt && !sq_prev) begin
                    sqrt_armed = 1'b1;
                    sqrt_cnt = sqrt_delay - 1;
                end
                if (sqrt_armed) begin
                    if (sqrt_cnt == 0) begin
                        bus.RDY_Sqrt = 1'b1;
                        sqrt_armed = 1'b0;
                    end else begin
                        sqrt_cnt--;
                    end
                end else if (spurious && bus.RST_Acc) begin
                    bus.RDY_Sqrt = 1'b1;
                end
            end
            sq_prev = bus.EN_Sqrt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job and compares everything observed on the bus against the job's arithmetic expectation.
    task automatic run_job(input int nv, input int vw, input bit md, input bit hold,
                           input int da, input int ds, input bit spur, input bit reissue);
        int nch, eda, per_vec, exp_lat, lat, rises, busy_bad, k;
        logic prev_sqrt;
        logic [11:0] rd_q[$];
        logic [7:0]  vi_q[$];
        logic [11:0] wr_q[$];
        logic        rs_q[$];
        logic        pre_q[$];

        nch = (vw + LANES - 1) / LANES;
        eda = hold ? 0 : da;
        per_vec = 1 + nch * (3 + eda) + (nch - 1) + (md ? 0 : (hold ? 1 : ds + 1)) + 1;
        exp_lat = (nv == 0 || vw == 0) ? 2 : 2 + nv * per_vec;

        acc_hold = hold;
        sqrt_hold = hold;
        acc_delay = da;
        sqrt_delay = ds;
        spurious = spur;
        rises = 0;
        busy_bad = 0;
        prev_sqrt = 1'b0;

        @(negedge clk);
        bus.NUM_OF_VECTORS = 8'(nv);
        bus.VECTOR_WIDTH = 8'(vw);
        bus.MODE = md;
        bus.STARTCALC = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.STARTCALC = 1'b0;
        bus.NUM_OF_VECTORS = 8'($urandom);
        bus.VECTOR_WIDTH = 8'($urandom);
        bus.MODE = 1'($urandom);
        while (lat < 20000) begin
            if (bus.FLAG_Bram == 3'b101 && !bus.EN_Pipe) begin
                rd_q.push_back(bus.ADDR_Bram);
                vi_q.push_back(bus.VEC_IDX);
            end
            if (bus.FLAG_Bram == 3'b110) begin
                wr_q.push_back(bus.ADDR_Bram);
                rs_q.push_back(bus.RES_SEL);
            end
            if (bus.RST_Acc) pre_q.push_back(bus.PRE_Acc);
            if (bus.EN_Sqrt && !prev_sqrt) rises++;
            prev_sqrt = bus.EN_Sqrt;
            if (bus.DONE) break;
            if (!bus.BUSY) busy_bad++;
            if (reissue && lat == 6) begin
                bus.STARTCALC = 1'b1;
                bus.NUM_OF_VECTORS = 8'(nv + 3);
            end else begin
                bus.STARTCALC = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end

        check("latency", lat, exp_lat);
        check("done_high", bus.DONE, 1'b1);
        check("busy_low_at_done", bus.BUSY, 1'b0);
        check("busy_during_job", busy_bad, 0);
        check("sqrt_enables", rises, md ? 0 : ((vw == 0) ? 0 : nv));
        check("read_count", rd_q.size(), (vw == 0) ? 0 : nv * nch);
        check("write_count", wr_q.size(), (vw == 0) ? 0 : nv);
        check("rst_acc_count", pre_q.size(), (vw == 0) ? 0 : nv * nch);
        k = 0;
        foreach (rd_q[i]) begin
            check("read_addr", rd_q[i], (DBASE + i * LANES) % 4096);
            check("read_vec_idx", vi_q[i], i / nch);
        end
        foreach (wr_q[i]) begin
            check("write_addr", wr_q[i], RBASE + i);
            check("res_sel", rs_q[i], !md);
        end
        foreach (pre_q[i]) begin
            if (pre_q[i] !== ((i % nch) != 0)) k++;
        end
        check("pre_acc_pattern", k, 0);

        @(negedge clk);
        check("done_one_cycle", bus.DONE, 1'b0);
        check("idle_flags", bus.FLAG_Bram, 3'b000);
    endtask

    initial begin
        bit seen, wrote;
        bus.STARTCALC = 1'b0;
        bus.NUM_OF_VECTORS = 8'd0;
        bus.VECTOR_WIDTH = 8'd0;
        bus.MODE = 1'b0;
        bus.RDY_Acc = 1'b0;
        bus.RDY_Sqrt = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.EN_Pipe, bus.EN_Acc, bus.RST_Acc, bus.PRE_Acc, bus.EN_Sqrt,
               bus.RES_SEL, bus.ADDR_Bram, bus.FLAG_Bram, bus.VEC_IDX, bus.BUSY, bus.DONE}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {bus.EN_Pipe, bus.EN_Acc, bus.RST_Acc, bus.BUSY, bus.DONE, bus.FLAG_Bram}, 32'd0);

        // Directed scenarios
        run_job(2, 8, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
        run_job(2, 5, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
        run_job(0, 8, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
        run_job(3, 0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
        run_job(2, 6, 1'b0, 1'b0, 10, 7, 1'b1, 1'b0);
        run_job(3, 8, 1'b0, 1'b1, 0, 1, 1'b0, 1'b1);

        // Asynchronous reset while waiting on sqrt
        acc_hold = 1'b0; sqrt_hold = 1'b0; acc_delay = 1; sqrt_delay = 30; spurious = 1'b0;
        @(negedge clk);
        bus.NUM_OF_VECTORS = 8'd2; bus.VECTOR_WIDTH = 8'd4; bus.MODE = 1'b0; bus.STARTCALC = 1'b1;
        @(negedge clk);
        bus.STARTCALC = 1'b0;
        seen = 1'b0;
        wrote = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.FLAG_Bram == 3'b110) wrote = 1'b1;
            if (bus.EN_Sqrt) seen = 1'b1;
        end
        check("sqrt_wait_reached", seen, 1'b1);
        check("no_write_before_abort", wrote, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {bus.EN_Pipe, bus.EN_Acc, bus.RST_Acc, bus.PRE_Acc, bus.EN_Sqrt,
               bus.RES_SEL, bus.ADDR_Bram, bus.FLAG_Bram, bus.VEC_IDX, bus.BUSY, bus.DONE}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        run_job(1, 4, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 4), $urandom_range(1, 16), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 4), $urandom_range(1, 4), 1'($urandom), 1'b0);
        end

        // Chunk count needing CW+1 bits, then maximum vector count with address wrap
        run_job(1, 255, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
        run_job(255, 20, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dist_sequencer.md
Name: dist_sequencer

Overview:
- Parametrised control sequencer for the distance datapath. For each of NUM_OF_VECTORS vectors it fetches the vector from BRAM in LANES-wide chunks, feeds the pipes, drives the accumulator (hard reset on the first chunk, preserve on later chunks), optionally runs the square root, and writes each result back to BRAM.
- Sits between the host start/status interface and the pipe/accumulator/sqrt/BRAM blocks.
- Adds over the previous control unit: parametrised widths and lane count, real BRAM addressing, result write-back, a squared-distance mode that bypasses sqrt, and BUSY/DONE status.

Parameters:
- CW, 8, width of NUM_OF_VECTORS, VECTOR_WIDTH and the internal counters.
- AW, 12, BRAM address width.
- LANES, 4, elements consumed per chunk; power of 2, at least 1.
- DATA_BASE, 0, BRAM address of element 0 of vector 0.
- RESULT_BASE, 2048, BRAM address of the result for vector 0.

Ports:
- clk  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- STARTCALC  in  1  start pulse; sampled only in IDLE.
- NUM_OF_VECTORS  in  CW  number of vectors; latched at start.
- VECTOR_WIDTH  in  CW  elements per vector; latched at start.
- MODE  in  1  0 = euclidean (sqrt), 1 = squared (no sqrt); latched at start.
- RDY_Acc  in  1  accumulator finished the current chunk.
- RDY_Sqrt  in  1  sqrt result valid.
- EN_Pipe  out  1  one-cycle pulse: BRAM data on the bus is valid for the pipes.
- EN_Acc  out  1  accumulator enable.
- RST_Acc  out  1  accumulator reset strobe.
- PRE_Acc  out  1  preserve sum during RST_Acc.
- EN_Sqrt  out  1  sqrt enable.
- RES_SEL  out  1  write-back mux: 0 = accumulator, 1 = sqrt.
- ADDR_Bram  out  AW  BRAM address.
- FLAG_Bram  out  3  {cs, we, oe}.
- VEC_IDX  out  CW  index of the vector in progress.
- BUSY  out  1  high from leaving IDLE until DONE.
- DONE  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (async, immediate, in any state): state goes to IDLE and all outputs are 0, including ADDR_Bram, FLAG_Bram, VEC_IDX, BUSY and DONE. Counters clear. Reset mid-job aborts without write-back.
- Registered Moore FSM. All outputs are registered and have no X values in any state. EN_Acc is high in every state except IDLE, FINISH and WRITE.
- Latched values: nvec, vwid, mode. Number of chunks nch = ceil(vwid/LANES), computed in CW+1 bits.
- Data pointer dptr (AW bits): starts at DATA_BASE and advances by LANES per chunk. Each vector occupies nch*LANES words; pad elements are zero-filled by software. Address arithmetic wraps modulo 2^AW.

FSM states and transitions:
- IDLE: if STARTCALC, latch inputs and set BUSY=1.
  - If nvec==0 or vwid==0, go to FINISH with no BRAM access.
  - Otherwise go to HARD_RST.
- HARD_RST (1 cycle): RST_Acc=1, PRE_Acc=0, EN_Acc=1; chunk counter = 0. Go to READ.
- READ (1 cycle): FLAG_Bram=101, ADDR_Bram=dptr. Go to FEED.
- FEED (1 cycle): EN_Pipe=1, FLAG_Bram=101 held. Increment dptr by LANES and the chunk counter by 1. Go to WAIT_ACC.
- WAIT_ACC: hold until RDY_Acc.
  - Chunk counter < nch: go to SOFT_RST.
  - Otherwise go to WAIT_SQRT if mode==0, or WRITE if mode==1.
- SOFT_RST (1 cycle): RST_Acc=1, PRE_Acc=1. Go to READ.
- WAIT_SQRT: EN_Sqrt=1 while waiting; when RDY_Sqrt is seen, go to WRITE.
- WRITE (1 cycle): FLAG_Bram=110, ADDR_Bram=RESULT_BASE+VEC_IDX, RES_SEL=~mode.
  - If VEC_IDX==nvec-1, go to FINISH.
  - Otherwise increment VEC_IDX and go to HARD_RST.
- FINISH (1 cycle): DONE=1, BUSY=0. Go to IDLE.

Boundary rules:
- STARTCALC outside IDLE is ignored. Input changes after start have no effect.
- RDY_Acc asserted during READ/FEED is ignored; only WAIT_ACC samples it. RDY_Sqrt is only sampled in WAIT_SQRT.
- RDY held high continuously: each WAIT state lasts exactly 1 cycle.
- nvec = 2^CW-1 must complete without VEC_IDX overflow.
- Outside READ, FEED and WRITE: FLAG_Bram=000 and ADDR_Bram holds its last value.
- Per-chunk latency with RDY_Acc already high is 4 cycles (SOFT_RST/HARD_RST, READ, FEED, WAIT_ACC).

Test Plan:
- LANES=4, VECTOR_WIDTH=8, NUM_OF_VECTORS=2, MODE=0, RDY_Acc and RDY_Sqrt held 1 -> reads at 0, 4, 8, 12; PRE_Acc sequence 0,1,0,1 on the RST_Acc strobes; writes at 2048 and 2049 with RES_SEL=1; DONE pulses once; BUSY high throughout.
- VECTOR_WIDTH=5, LANES=4, MODE=1 -> 2 chunks per vector; EN_Sqrt never asserted; write with RES_SEL=0 immediately after the second RDY_Acc.
- NUM_OF_VECTORS=0 (and separately VECTOR_WIDTH=0) -> FLAG_Bram stays 000; DONE 2 cycles after STARTCALC.
- RDY_Acc delayed 10 cycles, RDY_Sqrt delayed 7 cycles, plus a spurious RDY_Acc pulse during FEED -> FSM waits exactly; spurious pulse has no effect; outputs hold stable.
- RST asserted asynchronously mid-WAIT_SQRT, then STARTCALC reissued -> all outputs 0 immediately with no write; new job restarts from DATA_BASE with VEC_IDX=0.
- STARTCALC pulsed while BUSY, with NUM_OF_VECTORS changed -> ignored; original job count is honoured.
